// File: rtl/pc_sequencer.sv
// Program-counter controller for the 12-bit fetch path.
// Owns the PC register, the run/done handshake and a small call/return stack.
// The branch-target LUT is read combinationally: lut_addr mirrors br_idx and
// lut_target is consumed in the same cycle to pick the next PC.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; pc parked at START_PC, waiting for start
// RUN   | fetching; pc advances, branches, calls or returns every cycle
// HALT  | program finished (done) or faulted (err); waiting for start
module pc_sequencer #(
  parameter int unsigned   D        = 12,
  parameter logic [D-1:0]  START_PC = '0,
  parameter logic [D-1:0]  DONE_PC  = '1,
  parameter int unsigned   DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         taken,
  input  logic         call,
  input  logic         ret,
  input  logic [5:0]   br_idx,
  output logic [5:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic         err
);

  // Stack pointer must represent 0..DEPTH inclusive, so it gets one extra bit
  // over the stack index.
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state_q, state_n;
  logic [D-1:0]   pc_q, pc_n;
  logic [SPW-1:0] sp_q, sp_n;
  logic           err_q, err_n;
  logic           running_q, done_q;

  logic [D-1:0]   stack_mem [DEPTH];
  logic           push_en;
  logic [AW-1:0]  push_idx;
  logic [AW-1:0]  top_idx;
  logic [D-1:0]   top_val;
  logic [D-1:0]   pc_inc;
  logic           target_done;
  logic           target_bad;

  assign lut_addr = br_idx;
  assign pc       = pc_q;
  assign running  = running_q;
  assign done     = done_q;
  assign err      = err_q;

  // For sp in 1..DEPTH the low AW bits minus one give the top entry; for
  // sp == DEPTH the low bits are zero and the subtraction wraps to DEPTH-1.
  assign push_idx = sp_q[AW-1:0];
  assign top_idx  = sp_q[AW-1:0] - AW'(1);
  assign top_val  = stack_mem[top_idx];
  assign pc_inc   = pc_q + D'(1);

  // A target of DONE_PC is a clean finish; a zero target from a non-zero index
  // marks an unpopulated LUT entry and is treated as a fault.
  assign target_done = (lut_target == DONE_PC);
  assign target_bad  = (lut_target == '0) && (br_idx != 6'd0);

  // State, PC, stack pointer, fault flag and registered status decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      sp_q      <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      sp_q      <= sp_n;
      err_q     <= err_n;
      running_q <= (state_n == RUN);
      done_q    <= (state_n == HALT);
    end
  end

  // Return-stack storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    sp_n    = sp_q;
    err_n   = err_q;
    push_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_PC;
          sp_n    = '0;
          err_n   = 1'b0;
        end
      end

      RUN: begin
        if (!stall) begin
          if (call && ret) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else if (ret) begin
            if (sp_q == '0) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else begin
              sp_n = sp_q - SPW'(1);
              // A pushed DONE_PC (call from DONE_PC-1) finishes the program.
              if (top_val == DONE_PC) begin
                state_n = HALT;
              end else begin
                pc_n = top_val;
              end
            end
          end else if (call) begin
            if (sp_q == SP_FULL) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else if (target_done) begin
              state_n = HALT;
            end else if (target_bad) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else begin
              push_en = 1'b1;
              sp_n    = sp_q + SPW'(1);
              pc_n    = lut_target;
            end
          end else if (branch_en && taken) begin
            if (target_done) begin
              state_n = HALT;
            end else if (target_bad) begin
              err_n   = 1'b1;
              state_n = HALT;
            end else begin
              pc_n = lut_target;
            end
          end else begin
            // Reaching DONE_PC sequentially halts, so the PC never wraps in RUN.
            if (pc_inc == DONE_PC) begin
              state_n = HALT;
            end else begin
              pc_n = pc_inc;
            end
          end
        end
      end

      HALT: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_PC;
          sp_n    = '0;
          err_n   = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
        pc_n    = START_PC;
        sp_n    = '0;
        err_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. The stimulus process drives one input
// vector per cycle and queues the hand-computed outputs expected after the
// next rising edge; an independent monitor pops and compares them.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_en;
  logic        taken;
  logic        call;
  logic        ret;
  logic [5:0]  br_idx;
  logic [5:0]  lut_addr;
  logic [11:0] lut_target;
  logic [11:0] pc;
  logic        running;
  logic        done;
  logic        err;

  typedef struct {
    logic [11:0] pc;
    logic        run;
    logic        dn;
    logic        er;
    logic [5:0]  la;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .branch_en  (branch_en),
    .taken      (taken),
    .call       (call),
    .ret        (ret),
    .br_idx     (br_idx),
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at the falling edge and queue the expected
  // outputs for after the following rising edge.
  task automatic step(input logic rs, input logic st, input logic sl,
                      input logic be, input logic tk, input logic cl,
                      input logic rt, input logic [5:0] idx,
                      input logic [11:0] tgt, input logic [11:0] epc,
                      input logic erun, input logic edn, input logic eer,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset      = rs;
    start      = st;
    stall      = sl;
    branch_en  = be;
    taken      = tk;
    call       = cl;
    ret        = rt;
    br_idx     = idx;
    lut_target = tgt;
    e.pc  = epc;
    e.run = erun;
    e.dn  = edn;
    e.er  = eer;
    e.la  = idx;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Monitor: one comparison per queued expectation, sampled after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({pc, running, done, err, lut_addr} !== {e.pc, e.run, e.dn, e.er, e.la}) begin
          bad++;
          $display("FAIL %s: got pc=%0d running=%0b done=%0b err=%0b lut_addr=%0d, want pc=%0d running=%0b done=%0b err=%0b lut_addr=%0d",
                   e.nm, pc, running, done, err, lut_addr,
                   e.pc, e.run, e.dn, e.er, e.la);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    taken = 1'b0; call = 1'b0; ret = 1'b0; br_idx = '0; lut_target = '0;

    //    rs st sl be tk cl rt idx tgt      pc  run dn er
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,        0,   0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        0,   0, 0, 0, "idle_hold");
    step(0, 0, 1, 0, 0, 1, 0, 2, 34,       0,   0, 0, 0, "idle_ignore");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "start");
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0,      12'(i), 1, 0, 0, "seq");
    step(0, 0, 0, 1, 1, 0, 0, 4, 78,       78,  1, 0, 0, "br_taken");
    step(0, 0, 0, 1, 0, 0, 0, 4, 78,       79,  1, 0, 0, "br_not_taken");
    step(0, 0, 0, 0, 1, 0, 0, 4, 78,       80,  1, 0, 0, "taken_unqualified");
    step(0, 0, 0, 1, 1, 0, 0, 5, 10,       10,  1, 0, 0, "br_to_10");
    step(0, 0, 0, 0, 0, 1, 0, 2, 34,       34,  1, 0, 0, "call");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        35,  1, 0, 0, "start_in_run");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0,        11,  1, 0, 0, "ret");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0,        11,  0, 1, 1, "ret_empty");
    step(0, 0, 0, 1, 1, 1, 0, 3, 99,       11,  0, 1, 1, "halt_hold");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart");

    step(0, 0, 0, 0, 0, 1, 0, 1, 100,      100, 1, 0, 0, "call1");
    step(0, 0, 0, 0, 0, 1, 0, 2, 200,      200, 1, 0, 0, "call2");
    step(0, 0, 0, 0, 0, 1, 0, 3, 300,      300, 1, 0, 0, "call3");
    step(0, 0, 0, 0, 0, 1, 0, 4, 400,      400, 1, 0, 0, "call4");
    step(0, 0, 0, 0, 0, 1, 0, 5, 500,      400, 0, 1, 1, "call_overflow");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_after_overflow");

    step(0, 0, 1, 1, 1, 0, 0, 6, 700,      0,   1, 0, 0, "stall1");
    step(0, 1, 1, 1, 1, 0, 1, 6, 700,      0,   1, 0, 0, "stall2");
    step(0, 0, 1, 1, 1, 1, 0, 6, 700,      0,   1, 0, 0, "stall3");
    step(0, 0, 0, 1, 1, 0, 0, 6, 700,      700, 1, 0, 0, "stall_release");
    step(0, 0, 0, 0, 0, 1, 1, 1, 100,      700, 0, 1, 1, "call_ret_both");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_after_both");

    step(0, 0, 0, 1, 1, 0, 0, 0, 4095,     0,   0, 1, 0, "br_done");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_after_done");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        1,   1, 0, 0, "seq_a");
    step(0, 0, 0, 1, 1, 0, 0, 50, 0,       1,   0, 1, 1, "br_unpopulated");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_after_bad");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        1,   1, 0, 0, "seq_b");
    step(0, 0, 0, 1, 1, 0, 0, 0, 0,        0,   1, 0, 0, "br_idx0_to_0");
    step(0, 0, 0, 0, 0, 1, 0, 7, 4095,     0,   0, 1, 0, "call_done");

    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_c");
    step(0, 0, 0, 1, 1, 0, 0, 8, 4093,     4093, 1, 0, 0, "br_to_4093");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        4094, 1, 0, 0, "seq_4094");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        4094, 0, 1, 0, "seq_done");

    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_d");
    step(0, 0, 0, 1, 1, 0, 0, 9, 4094,     4094, 1, 0, 0, "br_to_4094");
    step(0, 0, 0, 0, 0, 1, 0, 10, 20,      20,  1, 0, 0, "call_push_done");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0,        20,  0, 1, 0, "ret_to_done");

    step(0, 1, 0, 0, 0, 0, 0, 0, 0,        0,   1, 0, 0, "restart_e");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        1,   1, 0, 0, "seq_c");
    step(1, 1, 1, 1, 1, 0, 0, 4, 78,       0,   0, 0, 0, "reset_mid_run");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0,        0,   0, 0, 0, "idle_after_reset");

    @(negedge clk);
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    taken = 1'b0; call = 1'b0; ret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
